// File: rtl/mini16_uart_rx.sv
// mini16_uart_rx: 8N1 UART receiver, LSB first, with a one-entry valid/ready
// output register and framing-error / overrun pulses.
//
// Ports:
//   clk       in   system clock, single clock domain (rising edge)
//   reset     in   synchronous active-high reset
//   uart_rxd  in   asynchronous serial input, idles high
//   data      out  received byte, stable while valid is high
//   valid     out  data holds an unconsumed byte
//   ready     in   consumer accepts the byte when valid && ready
//   busy      out  receiver FSM is not idle
//   ferr      out  one-cycle pulse: bad stop bit, byte discarded
//   overrun   out  one-cycle pulse: good byte dropped, output register full
module mini16_uart_rx #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SCLK_HZ = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       ferr,
  output logic       overrun
);

  localparam int unsigned DIV   = CLK_HZ / SCLK_HZ;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(DIV - 1);

  // Need at least a few clocks per bit for mid-bit sampling to make sense.
  if (DIV < 4) begin : g_div_check
    $error("mini16_uart_rx: CLK_HZ/SCLK_HZ must be at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Registers
  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_ferr;
  logic             r_overrun;

  // Next-state wires
  logic             w_rxd_s;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_ferr_nxt;
  logic             w_overrun_nxt;
  logic             w_deliver;

  assign w_rxd_s = r_sync2;

  assign data    = r_data;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign ferr    = r_ferr;
  assign overrun = r_overrun;

  // State register, synchronizer and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync1   <= uart_rxd;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_ferr    <= w_ferr_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_ferr_nxt    = 1'b0;
    w_overrun_nxt = 1'b0;
    w_deliver     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxd_s) begin
          w_state_nxt = S_START;
        end
      end

      // Confirm the start bit at its midpoint; a high line here is a glitch.
      S_START: begin
        if (r_cnt == CNT_HALF_END) begin
          w_cnt_nxt = '0;
          if (!w_rxd_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (r_cnt == CNT_BIT_END) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rxd_s, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // Leave at mid-stop-bit so the next start edge is caught early.
      S_STOP: begin
        if (r_cnt == CNT_BIT_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (w_rxd_s) begin
            w_deliver = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A byte consumed this cycle frees the slot for a same-cycle delivery.
    if (w_deliver) begin
      if (!r_valid || ready) begin
        w_data_nxt  = r_shift;
        w_valid_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (r_valid && ready) begin
      w_valid_nxt = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_mini16_uart_rx.sv
// Bench for mini16_uart_rx at DIV=16 / HALF=8. Serial frames are driven one
// clock after a rising edge; a negedge monitor logs every transfer, ferr,
// overrun and busy transition with its cycle number, and those logs are
// compared against expectations built from the frame-level timing rules.
module tb_mini16_uart_rx;

  localparam int unsigned CLK_HZ  = 1600000;
  localparam int unsigned SCLK_HZ = 100000;
  localparam int DIV  = int'(CLK_HZ / SCLK_HZ);
  localparam int HALF = DIV / 2;
  // Line driven just after edge n is first seen by IDLE at edge n+3 (T0).
  localparam int SYNC_LAT = 3;
  // Cycle (relative to the drive of the start bit) where a frame's result shows.
  localparam int T_DONE = SYNC_LAT + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       ferr;
  logic       overrun;

  mini16_uart_rx #(
    .CLK_HZ (CLK_HZ),
    .SCLK_HZ(SCLK_HZ)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rxd(uart_rxd),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy),
    .ferr    (ferr),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  // Observed event logs
  logic [7:0] q_rx_data[$];
  int         q_rx_cyc[$];
  int         q_ferr[$];
  int         q_ovr[$];
  int         q_brise[$];
  int         q_bfall[$];
  logic       prev_busy = 1'b0;
  int         n_both = 0;

  // Expected event lists and the consumer-side model
  logic [7:0] e_data[$];
  int         e_cyc[$];
  int         e_ferr[$];
  int         e_ovr[$];
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) begin
        q_rx_data.push_back(data);
        q_rx_cyc.push_back(cyc);
      end
      if (ferr)    q_ferr.push_back(cyc);
      if (overrun) q_ovr.push_back(cyc);
      if (ferr && overrun) n_both++;
    end
    if (busy !== prev_busy) begin
      if (busy === 1'b1) q_brise.push_back(cyc);
      else               q_bfall.push_back(cyc);
    end
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: what the consumer should see for one frame.
  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input int t);
    int done;
    done = t + T_DONE;
    if (!stop_bit) begin
      e_ferr.push_back(done);
    end else if (ready) begin
      e_data.push_back(b);
      e_cyc.push_back(done);
    end else if (!m_full) begin
      m_full = 1'b1;
      m_hold = b;
    end else begin
      e_ovr.push_back(done);
    end
  endtask

  task automatic drive_bit(input logic b);
    uart_rxd = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t);
    t = cyc;
    model_frame(b, stop_bit, t);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic consume_one();
    ready = 1'b1;
    if (m_full) begin
      e_data.push_back(m_hold);
      e_cyc.push_back(cyc);
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic clear_busy_log();
    q_brise.delete();
    q_bfall.delete();
  endtask

  task automatic compare_events(input string tag);
    check($sformatf("%s.rx_count", tag), q_rx_data.size(), e_data.size());
    for (int i = 0; i < q_rx_data.size() && i < e_data.size(); i++) begin
      check($sformatf("%s.rx_data[%0d]", tag, i), q_rx_data[i], e_data[i]);
      check($sformatf("%s.rx_cyc[%0d]", tag, i), q_rx_cyc[i], e_cyc[i]);
    end
    check($sformatf("%s.ferr_count", tag), q_ferr.size(), e_ferr.size());
    for (int i = 0; i < q_ferr.size() && i < e_ferr.size(); i++)
      check($sformatf("%s.ferr_cyc[%0d]", tag, i), q_ferr[i], e_ferr[i]);
    check($sformatf("%s.ovr_count", tag), q_ovr.size(), e_ovr.size());
    for (int i = 0; i < q_ovr.size() && i < e_ovr.size(); i++)
      check($sformatf("%s.ovr_cyc[%0d]", tag, i), q_ovr[i], e_ovr[i]);
    q_rx_data.delete(); q_rx_cyc.delete(); q_ferr.delete(); q_ovr.delete();
    e_data.delete();    e_cyc.delete();    e_ferr.delete(); e_ovr.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check($sformatf("%s.data", tag),    data,    8'h00);
    check($sformatf("%s.valid", tag),   valid,   1'b0);
    check($sformatf("%s.busy", tag),    busy,    1'b0);
    check($sformatf("%s.ferr", tag),    ferr,    1'b0);
    check($sformatf("%s.overrun", tag), overrun, 1'b0);
  endtask

  initial begin
    int t;
    int t2;
    int gap;
    logic [7:0] b;

    reset    = 1'b1;
    uart_rxd = 1'b1;
    ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    idle(10);

    // Single byte with timing of valid and busy
    clear_busy_log();
    send_frame(8'hA5, 1'b1, t);
    idle(20);
    compare_events("single");
    check("single.busy_rises", q_brise.size(), 1);
    check("single.busy_falls", q_bfall.size(), 1);
    if (q_brise.size() > 0) check("single.busy_rise_cyc", q_brise[0], t + SYNC_LAT);
    if (q_bfall.size() > 0) check("single.busy_fall_cyc", q_bfall[0], t + T_DONE);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, t);
    send_frame(8'hFF, 1'b1, t);
    send_frame(8'h5A, 1'b1, t);
    idle(20);
    compare_events("b2b");

    // Glitch rejection: 4-clock low pulse
    clear_busy_log();
    t = cyc;
    uart_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("glitch.busy_rises", q_brise.size(), 1);
    check("glitch.busy_falls", q_bfall.size(), 1);
    if (q_brise.size() > 0) check("glitch.busy_rise_cyc", q_brise[0], t + SYNC_LAT);
    if (q_bfall.size() > 0) check("glitch.busy_fall_cyc", q_bfall[0], t + SYNC_LAT + HALF);
    compare_events("glitch");
    send_frame(8'h3C, 1'b1, t);
    idle(20);
    compare_events("after_glitch");

    // Framing error, then a normal frame
    send_frame(8'h81, 1'b0, t);
    idle(40);
    check("ferr.valid_low", valid, 1'b0);
    compare_events("ferr");
    send_frame(8'h42, 1'b1, t);
    idle(20);
    compare_events("after_ferr");

    // Overrun with a stalled consumer
    ready = 1'b0;
    send_frame(8'h11, 1'b1, t);
    send_frame(8'h22, 1'b1, t2);
    idle(10);
    check("stall.valid", valid, 1'b1);
    check("stall.data", data, 8'h11);
    compare_events("overrun");
    idle(50);
    check("stall.valid_held", valid, 1'b1);
    check("stall.data_held", data, 8'h11);
    consume_one();
    @(negedge clk);
    check("stall.valid_dropped", valid, 1'b0);
    @(posedge clk);
    #1;
    compare_events("drain");
    ready = 1'b1;

    // Random bytes with random (possibly zero) gaps
    for (int k = 0; k < 8; k++) begin
      gap = int'($urandom_range(0, 24));
      idle(gap);
      b = 8'($urandom);
      send_frame(b, 1'b1, t);
    end
    idle(20);
    compare_events("random");

    // Reset during data bit 4
    b = 8'($urandom);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_rxd = b[4];
    repeat (HALF) @(posedge clk);
    #1;
    reset    = 1'b1;
    uart_rxd = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1;
    idle(40);
    compare_events("midreset_quiet");
    send_frame(8'hC3, 1'b1, t);
    idle(20);
    compare_events("after_reset");

    check("ferr_overrun_same_cycle", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mini16_uart_rx.md
# mini16_uart_rx

Byte-oriented UART receiver (8N1, LSB first) with a one-entry valid/ready output register and framing/overrun reporting. It sits on the receive end of the `uart_txd`/`uart_rxd` serial link. In `mini16_soc` it decodes host traffic on `uart_rxd` for the master CPU I/O registers. In simulation it decodes the SoC's `uart_txd` back into bytes for the bench.

## Interface
- `CLK_HZ`, default 50000000: system clock frequency.
- `SCLK_HZ`, default 115200: baud rate.
- Derived constants:
  - `DIV` = CLK_HZ / SCLK_HZ, truncated. It is the number of clocks per bit and must be ≥ 4; elaboration fails otherwise.
  - `HALF` = DIV / 2, truncated.

Ports:
- `clk` in 1: system clock. One clock only; everything is synchronous to its rising edge.
- `reset` in 1: synchronous, active-high.
- `uart_rxd` in 1: asynchronous serial input, idles high.
- `data` out 8: received byte, held stable while `valid` is high.
- `valid` out 1: `data` holds an unconsumed byte.
- `ready` in 1: consumer accepts the byte. The transfer happens on a cycle where `valid && ready`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `ferr` out 1: one-cycle pulse when a frame has a bad stop bit.
- `overrun` out 1: one-cycle pulse when a completed byte is dropped because the output register is full.

## Operation
- **Synchronizer:** two flops, both reset to 1. `rxd_s` is the second flop's output. All decisions use `rxd_s`.
- **FSM states:** IDLE, START, DATA, STOP. A cycle counter `cnt` and a bit index `idx` (0..7) support the FSM.
- **IDLE:**
  - `rxd_s==0` → START, `cnt←0`.
  - Call this edge T0.
- **START:**
  - `cnt` increments each cycle.
  - At `cnt==HALF-1`, sample `rxd_s`:
    - 0 → DATA, `cnt←0`, `idx←0`.
    - 1 → IDLE. This is a glitch; nothing is reported.
- **DATA:**
  - At `cnt==DIV-1`, shift `rxd_s` into the shift register LSB-first and set `cnt←0`.
  - After bit 7 → STOP; otherwise `idx++`.
- **STOP:**
  - At `cnt==DIV-1`, sample `rxd_s`:
    - 1 → frame good; deliver the byte to the output register.
    - 0 → `ferr` pulse; discard the byte.
  - Either way → IDLE on the same edge.
  - Returning at mid-stop-bit lets the next start edge be caught with up to half a bit of margin.
- **Output register, on a good-frame delivery:**
  - `!valid` or `ready` (consumed this cycle): load `data`, `valid←1`.
  - `valid && !ready`: keep the old byte and `valid`, drop the new one, pulse `overrun`.
- **Output register, with no delivery:** `valid && ready` → `valid←0`. `data` keeps its last value.
- `ferr` and `overrun` are registered. They are high for exactly one cycle per event and never both in the same cycle.
- Reset mid-frame: the FSM returns to IDLE and the partial byte is discarded. No `ferr` or `overrun` is produced.

## Timing
- Reset values:
  - `data`=0, `valid`=0, `busy`=0, `ferr`=0, `overrun`=0.
  - FSM=IDLE, `cnt`=0, sync flops=1.
- Input latency: a `uart_rxd` falling edge reaches `rxd_s` 2 clocks later. T0 is the first edge at which IDLE sees `rxd_s==0`.
- Sample edges, relative to T0:
  - Start bit: T0+HALF.
  - Data bit k: T0+HALF+(k+1)·DIV.
  - Stop bit: T0+HALF+9·DIV.
- After the stop sample:
  - `valid` (or `ferr`/`overrun`) is high from the cycle following the stop-sample edge.
  - `busy` falls on the same edge that raises `valid`.
- `busy` rises on edge T0.
- Back-to-back frames with no idle gap are received without loss.
- `valid` may stay high indefinitely; `data` does not change while `valid && !ready`.

## Test plan
Use `CLK_HZ=1600000` and `SCLK_HZ=100000`, giving DIV=16 and HALF=8. The bench drives `uart_rxd` with 16-clock bits.
- **Single byte:** send 0xA5 with `ready`=1. `valid` pulses for 1 cycle with `data`=0xA5 at T0+8+9·16+1 = T0+153. `busy` is high T0..T0+152. `ferr`=`overrun`=0.
- **Back-to-back:** send 0x00, 0xFF, 0x5A with no gaps and `ready`=1. Exactly three `valid` pulses occur, with data 0x00, 0xFF, 0x5A in order, spaced 160 clocks apart.
- **Glitch rejection:** a 4-clock low pulse on idle `uart_rxd`. `busy` rises, then returns to 0 at T0+8. No `valid` and no `ferr` is produced. A following 0x3C is received correctly.
- **Framing error:** send 0x81 with stop bit=0, then line high. One `ferr` pulse at T0+153; `valid` stays 0. A following 0x42 is received normally.
- **Overrun and stall:** hold `ready`=0 and send 0x11 then 0x22. `valid` stays high with `data`=0x11. One `overrun` pulse occurs at the second frame's completion. Raising `ready` for 1 cycle then drops `valid` to 0.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 4 of a frame. All outputs return to 0 and `busy`=0. A fresh 0xC3 sent afterwards is received correctly with no `ferr`.
